// File: rtl/pwm_ramp_bank.sv
// Multi-channel PWM generator with a shared prescaled period counter.
// Duty targets are shadowed on load, applied at period boundaries, and can optionally soft-ramp.
module pwm_ramp_bank #(
    parameter int unsigned CH       = 10,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESC    = 1,
    parameter int unsigned RAMP_DIV = 4,
    parameter int unsigned STEP     = 8,
    parameter int unsigned FULL_ON  = 1
) (
    input  logic                  clk25M,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [CH*WIDTH-1:0]   duty_target,
    input  logic [CH-1:0]         ramp_en,
    input  logic [CH-1:0]         ch_enable,
    output logic [CH-1:0]         pwm_out,
    output logic [CH*WIDTH-1:0]   duty_cur,
    output logic [CH-1:0]         ramp_busy,
    output logic                  period_start
);

    localparam int unsigned PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int unsigned RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESC - 1);
    localparam logic [RW-1:0]    RDIV_LAST  = RW'(RAMP_DIV - 1);
    localparam logic [WIDTH:0]   STEP_W     = (WIDTH + 1)'(STEP);

    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [RW-1:0]    rdiv_q, rdiv_d;
    logic             period_start_q;
    logic             tick, boundary, step_now;

    always_comb begin
        tick     = (presc_q == PRESC_LAST);
        presc_d  = tick ? '0 : presc_q + 1'b1;
        cnt_d    = tick ? cnt_q + 1'b1 : cnt_q;
        boundary = tick && (cnt_q == '1);
        step_now = boundary && (rdiv_q == RDIV_LAST);
        rdiv_d   = rdiv_q;
        if (boundary) begin
            rdiv_d = step_now ? '0 : rdiv_q + 1'b1;
        end
    end

    always_ff @(posedge clk25M or negedge rst_n) begin
        if (!rst_n) begin
            presc_q        <= '0;
            cnt_q          <= '0;
            rdiv_q         <= '0;
            period_start_q <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            cnt_q          <= cnt_d;
            rdiv_q         <= rdiv_d;
            period_start_q <= boundary;
        end
    end

    assign period_start = period_start_q;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [WIDTH-1:0] tgt_q, duty_q, duty_d, stepped;
        logic             ramp_q, pwm_q, pwm_d;
        logic [WIDTH:0]   cur_w, tgt_w, inc_w, dec_w;

        // Step math is done one bit wider so the clamp comparison never wraps.
        always_comb begin
            cur_w   = {1'b0, duty_q};
            tgt_w   = {1'b0, tgt_q};
            inc_w   = cur_w + STEP_W;
            dec_w   = cur_w - STEP_W;
            stepped = duty_q;
            if (tgt_w > cur_w) begin
                stepped = ((tgt_w - cur_w) <= STEP_W) ? tgt_q : inc_w[WIDTH-1:0];
            end else if (cur_w > tgt_w) begin
                stepped = ((cur_w - tgt_w) <= STEP_W) ? tgt_q : dec_w[WIDTH-1:0];
            end
        end

        always_comb begin
            duty_d = duty_q;
            if (boundary) begin
                if (!ch_enable[i]) begin
                    duty_d = '0;
                end else if (!ramp_q) begin
                    duty_d = tgt_q;
                end else if (step_now) begin
                    duty_d = stepped;
                end
            end
            pwm_d = ch_enable[i] &&
                    ((cnt_q < duty_q) || ((FULL_ON != 0) && (duty_q == '1)));
        end

        // Shadows are written on load only; the boundary above still sees the old values.
        always_ff @(posedge clk25M or negedge rst_n) begin
            if (!rst_n) begin
                tgt_q  <= '0;
                ramp_q <= 1'b0;
                duty_q <= '0;
                pwm_q  <= 1'b0;
            end else begin
                if (load) begin
                    tgt_q  <= duty_target[i*WIDTH +: WIDTH];
                    ramp_q <= ramp_en[i];
                end
                duty_q <= duty_d;
                pwm_q  <= pwm_d;
            end
        end

        assign pwm_out[i]                   = pwm_q;
        assign duty_cur[i*WIDTH +: WIDTH]   = duty_q;
        assign ramp_busy[i]                 = (duty_q != tgt_q);
    end

endmodule

// File: tb/tb_pwm_ramp_bank.sv
// Scoreboard bench for pwm_ramp_bank: expected duties are queued with each stimulus
// and compared when the next period_start pulse appears.
module tb_pwm_ramp_bank;

    localparam int CH = 4;
    localparam int W  = 8;

    logic            clk25M = 1'b0;
    logic            rst_n;
    logic            load;
    logic [CH*W-1:0] duty_target;
    logic [CH-1:0]   ramp_en;
    logic [CH-1:0]   ch_enable;
    logic [CH-1:0]   pwm_out;
    logic [CH*W-1:0] duty_cur;
    logic [CH-1:0]   ramp_busy;
    logic            period_start;

    always #5 clk25M = ~clk25M;

    pwm_ramp_bank #(
        .CH       (CH),
        .WIDTH    (W),
        .PRESC    (1),
        .RAMP_DIV (1),
        .STEP     (16),
        .FULL_ON  (1)
    ) dut (
        .clk25M       (clk25M),
        .rst_n        (rst_n),
        .load         (load),
        .duty_target  (duty_target),
        .ramp_en      (ramp_en),
        .ch_enable    (ch_enable),
        .pwm_out      (pwm_out),
        .duty_cur     (duty_cur),
        .ramp_busy    (ramp_busy),
        .period_start (period_start)
    );

    typedef struct {
        string tag;
        int    ch;
        int    duty;
    } exp_t;

    exp_t            exp_q[$];
    int              checks   = 0;
    int              failures = 0;
    logic [CH*W-1:0] tgt_all  = '0;
    logic [CH-1:0]   ramp_all = '0;

    task automatic check_eq(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int duty_of(input int ch);
        return int'(duty_cur[ch*W +: W]);
    endfunction

    task automatic expect_duty(input string tag, input int ch, input int duty);
        exp_t e;
        e.tag  = tag;
        e.ch   = ch;
        e.duty = duty;
        exp_q.push_back(e);
    endtask

    // Advance to the next period_start pulse, then drain the scoreboard.
    task automatic next_period(input string tag);
        int   n;
        exp_t e;
        n = 0;
        do begin
            @(negedge clk25M);
            n++;
        end while (!period_start && n < 600);
        check_eq({tag, "_pulse"}, int'(period_start), 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq(e.tag, duty_of(e.ch), e.duty);
        end
    endtask

    task automatic load_targets();
        duty_target = tgt_all;
        ramp_en     = ramp_all;
        load        = 1'b1;
        @(negedge clk25M);
        load        = 1'b0;
    endtask

    // Count high samples over one full period; the window ends on the next pulse.
    task automatic count_high(input string tag, input int ch, input int exp);
        int n;
        n = 0;
        repeat (256) begin
            @(negedge clk25M);
            n += int'(pwm_out[ch]);
        end
        check_eq(tag, n, exp);
        check_eq({tag, "_spacing"}, int'(period_start), 1);
    endtask

    task automatic cycles_to_pulse(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk25M);
            n++;
        end while (!period_start && n < 600);
        check_eq(tag, n, 256);
    endtask

    int up_seq[4]   = '{16, 32, 48, 50};
    int down_seq[4] = '{34, 18, 2, 0};

    initial begin
        rst_n       = 1'b0;
        load        = 1'b0;
        duty_target = '0;
        ramp_en     = '0;
        ch_enable   = '0;
        repeat (3) @(negedge clk25M);
        check_eq("rst_duty", int'(duty_cur), 0);
        check_eq("rst_pwm", int'(pwm_out), 0);
        check_eq("rst_busy", int'(ramp_busy), 0);
        check_eq("rst_ps", int'(period_start), 0);
        rst_n = 1'b1;
        cycles_to_pulse("first_ps");

        // Immediate apply at boundary, no ramp
        ch_enable    = 4'hF;
        tgt_all[7:0] = 8'd64;
        load_targets();
        check_eq("s2_hold", duty_of(0), 0);
        check_eq("s2_busy", int'(ramp_busy[0]), 1);
        expect_duty("s2_apply", 0, 64);
        next_period("s2");
        count_high("s2_high", 0, 64);

        // Ramp up then down on ch1
        tgt_all[15:8] = 8'd50;
        ramp_all[1]   = 1'b1;
        load_targets();
        for (int i = 0; i < 4; i++) begin
            expect_duty($sformatf("s3_up%0d", i), 1, up_seq[i]);
            next_period("s3u");
            if (i == 2) check_eq("s3_busy_mid", int'(ramp_busy[1]), 1);
        end
        check_eq("s3_busy_done", int'(ramp_busy[1]), 0);
        tgt_all[15:8] = 8'd0;
        load_targets();
        for (int i = 0; i < 4; i++) begin
            expect_duty($sformatf("s3_dn%0d", i), 1, down_seq[i]);
            next_period("s3d");
        end
        check_eq("s3_busy_end", int'(ramp_busy[1]), 0);

        // Full-on and back to off on ch2
        tgt_all[23:16] = 8'd255;
        load_targets();
        expect_duty("s4_full", 2, 255);
        next_period("s4a");
        count_high("s4_on", 2, 256);
        tgt_all[23:16] = 8'd0;
        load_targets();
        expect_duty("s4_zero", 2, 0);
        next_period("s4b");
        count_high("s4_off", 2, 0);

        // Load landing exactly on the boundary cycle
        tgt_all[31:24] = 8'd10;
        load_targets();
        expect_duty("s5_ten", 3, 10);
        next_period("s5a");
        repeat (255) @(negedge clk25M);
        tgt_all[31:24] = 8'd200;
        duty_target    = tgt_all;
        ramp_en        = ramp_all;
        load           = 1'b1;
        @(negedge clk25M);
        load = 1'b0;
        check_eq("s5_edge", int'(period_start), 1);
        check_eq("s5_old", duty_of(3), 10);
        check_eq("s5_busy", int'(ramp_busy[3]), 1);
        expect_duty("s5_new", 3, 200);
        next_period("s5b");

        // Disable mid-ramp then soft-restart from 0
        tgt_all[7:0] = 8'd200;
        ramp_all[0]  = 1'b1;
        load_targets();
        expect_duty("s6_r80", 0, 80);
        next_period("s6a");
        expect_duty("s6_r96", 0, 96);
        next_period("s6b");
        repeat (10) @(negedge clk25M);
        check_eq("s6_pwm_on", int'(pwm_out[0]), 1);
        ch_enable[0] = 1'b0;
        @(negedge clk25M);
        check_eq("s6_pwm_off", int'(pwm_out[0]), 0);
        check_eq("s6_hold", duty_of(0), 96);
        expect_duty("s6_cleared", 0, 0);
        next_period("s6c");
        ch_enable[0] = 1'b1;
        expect_duty("s6_re16", 0, 16);
        next_period("s6d");
        expect_duty("s6_re32", 0, 32);
        next_period("s6e");

        // Asynchronous reset in the middle of a period
        repeat (100) @(negedge clk25M);
        check_eq("s1_pwm_pre", int'(pwm_out[3]), 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("s1_pwm", int'(pwm_out), 0);
        check_eq("s1_duty", int'(duty_cur), 0);
        check_eq("s1_busy", int'(ramp_busy), 0);
        check_eq("s1_ps", int'(period_start), 0);
        @(negedge clk25M);
        rst_n = 1'b1;
        cycles_to_pulse("s1_first_ps");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
